// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage that sits directly behind the program counter. It takes one
// fetch address at a time from the PC and issues a single read to instruction
// memory. It waits for that read for as many cycles as memory needs. Each
// returned word is queued together with its fetch address in a small circular
// FIFO for decode. A flush (taken jump/branch) discards the queued entries and
// the read that is in flight.
//
// Handshake rule used on every valid/ready pair in this block: a transfer
// happens on a rising edge where valid and ready are both 1. The producer
// holds its payload stable while valid=1 and ready=0. Neither side waits
// for the other before raising its own signal, except that pc_ready
// combinationally depends on flush.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous, active-high reset
//   pc_addr    : fetch address from the program counter
//   pc_valid   : pc_addr is valid
//   pc_ready   : fetch accepts pc_addr this cycle (combinational)
//   mem_req    : read request to instruction memory (registered)
//   mem_addr   : read address, held stable while mem_req=1
//   mem_ack    : memory returns mem_rdata this cycle
//   mem_rdata  : instruction word, valid with mem_ack
//   flush      : discard queued and in-flight fetches
//   inst_valid : FIFO head is valid for decode
//   inst_data  : instruction at the FIFO head
//   inst_pc    : fetch address of inst_data
//   inst_ready : decode consumes the head this cycle
//   fsm_state  : debug view of the request FSM (0=IDLE, 1=WAIT, 2=DRAIN)
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_addr,
    input  logic             pc_valid,
    output logic             pc_ready,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             flush,
    output logic             inst_valid,
    output logic [WIDTH-1:0] inst_data,
    output logic [WIDTH-1:0] inst_pc,
    input  logic             inst_ready,
    output logic [1:0]       fsm_state
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             mem_req_next;
    logic [WIDTH-1:0] mem_addr_next;

    logic             pc_fire;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    // Acceptance is gated on free FIFO space, so the single outstanding read
    // always has somewhere to land and a push can never overflow.
    assign pc_ready   = (state == IDLE) && (count < DEPTH_C) && !flush;
    assign pc_fire    = pc_valid && pc_ready;
    // A word returning in the same cycle as a flush belongs to the discarded path.
    assign push       = (state == WAIT) && mem_ack && !flush;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;

    assign inst_data  = data_mem[rd_ptr];
    assign inst_pc    = pc_mem[rd_ptr];
    assign fsm_state  = state;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state    <= state_next;
            mem_req  <= mem_req_next;
            mem_addr <= mem_addr_next;
        end
    end

    always_comb begin
        state_next    = state;
        mem_req_next  = mem_req;
        mem_addr_next = mem_addr;
        case (state)
            IDLE: begin
                if (pc_fire) begin
                    state_next    = WAIT;
                    mem_req_next  = 1'b1;
                    mem_addr_next = pc_addr;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    // Data is pushed (or dropped on flush) by the FIFO logic.
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                end else if (flush) begin
                    // Memory still owes a response; keep the request up and
                    // swallow whatever comes back.
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                end
            end
            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (flush) begin
            // Emptying by snapping the read pointer to the write pointer; a
            // simultaneous pop is simply absorbed into the flush.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= mem_rdata;
                pc_mem[wr_ptr]   <= mem_addr;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
